// File: rtl/nw_systolic_scorer.sv
// Linear systolic Needleman-Wunsch scorer: one PE per query character,
// subject streamed through the PE row, final H[len1][len2] returned.
module nw_systolic_scorer #(
  parameter int PE_COUNT = 16,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int LWIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [SWIDTH-1:0] cfg_match,
  input  logic signed [SWIDTH-1:0] cfg_mismatch,
  input  logic signed [SWIDTH-1:0] cfg_indel,
  input  logic                     q_load,
  input  logic [CWIDTH-1:0]        q_char,
  input  logic                     q_clear,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [CWIDTH-1:0]        s_char,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [LWIDTH-1:0]        q_len,
  output logic                     q_full,
  output logic                     busy,
  output logic signed [SWIDTH-1:0] score,
  output logic                     score_valid
);

  localparam int KW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_d;

  logic signed [SWIDTH-1:0] w_match, w_mis, w_indel;
  logic [CWIDTH-1:0]        q_mem [PE_COUNT];

  logic                     hs, idle, start_ok, done;
  logic [KW-1:0]            li;
  logic signed [SWIDTH-1:0] bnd, bnd_nx, acc;

  logic                     in_v, in_last;
  logic [CWIDTH-1:0]        in_c;
  logic signed [SWIDTH-1:0] in_left, in_diag;

  // Registers toward PE k+1; d[k] holds the diag for PE k+1.
  logic                     pv [PE_COUNT-1];
  logic                     pl [PE_COUNT-1];
  logic [CWIDTH-1:0]        pc [PE_COUNT-1];
  logic signed [SWIDTH-1:0] d  [PE_COUNT-1];
  logic signed [SWIDTH-1:0] h  [PE_COUNT];

  logic                     iv   [PE_COUNT];
  logic                     il   [PE_COUNT];
  logic [CWIDTH-1:0]        ic   [PE_COUNT];
  logic signed [SWIDTH-1:0] left [PE_COUNT];
  logic signed [SWIDTH-1:0] diag [PE_COUNT];
  logic signed [SWIDTH-1:0] hn   [PE_COUNT];
  logic signed [SWIDTH-1:0] init [PE_COUNT];

  function automatic logic signed [SWIDTH-1:0] max3(
    input logic signed [SWIDTH-1:0] a,
    input logic signed [SWIDTH-1:0] b,
    input logic signed [SWIDTH-1:0] c
  );
    logic signed [SWIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign idle    = (state == IDLE);
  assign s_ready = (state == RUN);
  assign busy    = !idle;
  assign hs      = s_valid & s_ready;
  assign bnd_nx  = bnd + w_indel;
  assign li      = KW'(q_len - LWIDTH'(1));
  assign start_ok = idle && start &&
                    ((q_len != '0) || (q_load && !q_clear));
  assign done    = (state == DRAIN) && iv[li] && il[li];

  always_comb begin
    acc = '0;
    for (int k = 0; k < PE_COUNT; k++) begin
      acc     = acc + cfg_indel;
      init[k] = acc;
    end
    iv[0]   = in_v;
    il[0]   = in_last;
    ic[0]   = in_c;
    left[0] = in_left;
    diag[0] = in_diag;
    for (int k = 1; k < PE_COUNT; k++) begin
      iv[k]   = pv[k-1];
      il[k]   = pl[k-1];
      ic[k]   = pc[k-1];
      left[k] = h[k-1];
      diag[k] = d[k-1];
    end
    for (int k = 0; k < PE_COUNT; k++) begin
      hn[k] = max3(diag[k] + ((ic[k] == q_mem[k]) ? w_match : w_mis),
                   h[k] + w_indel,
                   left[k] + w_indel);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (hs && s_last) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      q_len       <= '0;
      q_full      <= 1'b0;
      score       <= '0;
      score_valid <= 1'b0;
      w_match     <= '0;
      w_mis       <= '0;
      w_indel     <= '0;
      bnd         <= '0;
      in_v        <= 1'b0;
      in_last     <= 1'b0;
      in_c        <= '0;
      in_left     <= '0;
      in_diag     <= '0;
      for (int k = 0; k < PE_COUNT; k++) begin
        q_mem[k] <= '0;
        h[k]     <= '0;
      end
      for (int k = 0; k < PE_COUNT-1; k++) begin
        pv[k] <= 1'b0;
        pl[k] <= 1'b0;
        pc[k] <= '0;
        d[k]  <= '0;
      end
    end else begin
      state       <= state_d;
      score_valid <= done;
      if (done) score <= hn[li];
      if (idle && q_clear) begin
        q_len  <= '0;
        q_full <= 1'b0;
      end else if (idle && q_load) begin
        if (q_len == LWIDTH'(PE_COUNT)) begin
          q_full <= 1'b1;
        end else begin
          q_mem[q_len[KW-1:0]] <= q_char;
          q_len <= q_len + LWIDTH'(1);
        end
      end
      in_v    <= hs;
      in_last <= hs & s_last;
      if (hs) begin
        in_c    <= s_char;
        in_left <= bnd_nx;
        in_diag <= bnd;
        bnd     <= bnd_nx;
      end
      for (int k = 0; k < PE_COUNT-1; k++) begin
        pv[k] <= iv[k];
        if (iv[k]) begin
          pc[k] <= ic[k];
          pl[k] <= il[k];
        end
      end
      for (int k = 1; k < PE_COUNT; k++) begin
        if (iv[k]) d[k-1] <= left[k];
      end
      for (int k = 0; k < PE_COUNT; k++) begin
        if (iv[k]) h[k] <= hn[k];
      end
      // Row 0 boundary: H[0][j] = j*indel, built by repeated addition.
      if (start_ok) begin
        w_match <= cfg_match;
        w_mis   <= cfg_mismatch;
        w_indel <= cfg_indel;
        bnd     <= '0;
        in_v    <= 1'b0;
        for (int k = 0; k < PE_COUNT; k++) h[k] <= init[k];
        for (int k = 0; k < PE_COUNT-1; k++) begin
          pv[k] <= 1'b0;
          d[k]  <= init[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_nw_systolic_scorer.sv
// Scoreboard bench for nw_systolic_scorer: directed runs with
// hand-computed scores and latencies, plus query/reset corner cases.
module tb_nw_systolic_scorer;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] cfg_match, cfg_mismatch, cfg_indel;
  logic q_load, q_clear, start, s_valid, s_last;
  logic [1:0] q_char, s_char;
  logic s_ready, q_full, busy, score_valid;
  logic [7:0] q_len;
  logic signed [15:0] score;

  nw_systolic_scorer #(
    .PE_COUNT(16), .CWIDTH(2), .SWIDTH(16), .LWIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_indel(cfg_indel),
    .q_load(q_load), .q_char(q_char), .q_clear(q_clear),
    .start(start), .s_valid(s_valid), .s_char(s_char),
    .s_last(s_last), .s_ready(s_ready), .q_len(q_len),
    .q_full(q_full), .busy(busy), .score(score),
    .score_valid(score_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (score_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_score_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("score", int'(score), e.s);
        check("latency_cycle", cyc, e.c);
        check("busy_at_valid", int'(busy), 0);
      end
    end
  end

  task automatic load_str(input int n, input logic [31:0] s);
    for (int k = 0; k < n; k++) begin
      q_load = 1'b1;
      q_char = s[2*k +: 2];
      tick();
    end
    q_load = 1'b0;
  endtask

  task automatic clear_q();
    q_clear = 1'b1;
    tick();
    q_clear = 1'b0;
  endtask

  task automatic set_w(input int m, input int mm, input int id);
    cfg_match    = 16'(m);
    cfg_mismatch = 16'(mm);
    cfg_indel    = 16'(id);
  endtask

  task automatic stream(input int qn, input int sn,
                        input logic [31:0] subj, input bit gap,
                        input int exp_score);
    exp_t e;
    for (int k = 0; k < sn; k++) begin
      s_valid = 1'b1;
      s_char  = subj[2*k +: 2];
      s_last  = (k == sn - 1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (k == sn - 1) begin
        e.s = exp_score;
        e.c = cyc + qn;
        sb.push_back(e);
      end else if (gap) begin
        tick();
      end
    end
    for (int t = 0; t < 60 && sb.size() > 0; t++) tick();
    if (sb.size() != 0) begin
      check("score_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  task automatic run(input int qn, input int sn, input logic [31:0] subj,
                     input bit gap, input int exp_score);
    start = 1'b1;
    tick();
    start = 1'b0;
    stream(qn, sn, subj, gap, exp_score);
  endtask

  initial begin
    reset = 1'b0;
    q_load = 1'b0; q_clear = 1'b0; start = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; q_char = '0; s_char = '0;
    set_w(1, -1, -1);
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_score", int'(score), 0);
    check("rst_score_valid", int'(score_valid), 0);
    check("rst_q_len", int'(q_len), 0);
    check("rst_q_full", int'(q_full), 0);
    reset = 1'b1;
    tick();

    load_str(4, 32'hE4);
    check("q_len_acgt", int'(q_len), 4);
    run(4, 4, 32'hE4, 1'b0, 4);
    run(4, 3, 32'h38, 1'b0, 2);
    run(4, 4, 32'hE4, 1'b1, 4);

    clear_q();
    load_str(1, 32'h0);
    run(1, 1, 32'h1, 1'b0, -1);

    clear_q();
    load_str(2, 32'h4);
    set_w(2, -3, -2);
    run(2, 2, 32'h8, 1'b0, -1);
    set_w(1, -1, -1);
    run(2, 2, 32'h8, 1'b0, 0);
    run(2, 4, 32'hE4, 1'b0, 0);

    clear_q();
    q_load = 1'b1;
    q_char = 2'd0;
    start  = 1'b1;
    tick();
    q_load = 1'b0;
    start  = 1'b0;
    check("load_start_q_len", int'(q_len), 1);
    check("load_start_busy", int'(busy), 1);
    stream(1, 1, 32'h0, 1'b0, 1);

    clear_q();
    for (int k = 0; k < 17; k++) load_str(1, 32'(k % 4));
    check("full_q_len", int'(q_len), 16);
    check("full_q_full", int'(q_full), 1);
    clear_q();
    check("clear_q_len", int'(q_len), 0);
    check("clear_q_full", int'(q_full), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", int'(busy), 0);
    tick();
    check("empty_start_busy2", int'(busy), 0);

    load_str(4, 32'hE4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", int'(busy), 1);
    check("run_s_ready", int'(s_ready), 1);
    s_valid = 1'b1;
    s_char  = 2'd0;
    tick();
    s_char  = 2'd1;
    tick();
    s_valid = 1'b0;
    reset   = 1'b0;
    tick();
    reset   = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_s_ready", int'(s_ready), 0);
    check("abort_q_len", int'(q_len), 0);
    check("abort_score", int'(score), 0);
    for (int t = 0; t < 10; t++) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nw_systolic_scorer.md
# nw_systolic_scorer

Linear systolic Needleman-Wunsch global-alignment scorer. It supersedes the fixed square cell grid with a row of `PE_COUNT` processing elements. A query string of 1..`PE_COUNT` characters is loaded once, then a subject string of any length is streamed in one character per accepted handshake, with backpressure-free bubbles allowed. Match, mismatch and indel weights are run-time inputs latched at start. One final score is returned per run.

## Interface
- `PE_COUNT`, 16: maximum query length, one PE per query character.
- `CWIDTH`, 2: bits per character.
- `SWIDTH`, 16: bits per signed score.
- `LWIDTH`, 8: width of the query-length counter; must satisfy 2^LWIDTH > `PE_COUNT`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `cfg_match` / `cfg_mismatch` / `cfg_indel` in `SWIDTH` each: signed weights, sampled on the cycle `start` is accepted.
- `q_load` in 1: append `q_char` to the query (IDLE only).
- `q_char` in `CWIDTH`: query character.
- `q_clear` in 1: empty the query (IDLE only); takes priority over `q_load`.
- `start` in 1: begin a run.
- `s_valid` in 1: subject character present.
- `s_char` in `CWIDTH`: subject character.
- `s_last` in 1: marks the final subject character.
- `s_ready` out 1: subject input is accepted.
- `q_len` out `LWIDTH`: current query length.
- `q_full` out 1: sticky; set when a load is attempted while `q_len` == `PE_COUNT`. Cleared by `q_clear` or reset.
- `busy` out 1: state is not IDLE.
- `score` out `SWIDTH` signed: final alignment score, H[len1][len2].
- `score_valid` out 1: one-cycle pulse when `score` is updated.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `q_load` writes `q_char` into slot `q_len` and increments `q_len`. A load when full is dropped and sets `q_full`.
  - `start` with `q_len` > 0 latches the weights, clears all PE state and moves to RUN.
  - `start` with `q_len` == 0 is ignored.
- RUN:
  - `s_ready` = 1; a handshake is `s_valid & s_ready`.
  - Each accepted character enters PE0 tagged with row index i (1-based, internal counter).
  - Cycles with no handshake inject a bubble: PE state is held and no row is computed.
  - The handshake that carries `s_last` moves the state to DRAIN, and `s_ready` drops on the next cycle.
- DRAIN: lasts until the last row leaves PE `q_len`-1. Then `score_valid` pulses and the state returns to IDLE. The query is retained for reuse.
- PE k (query char q[k], column j = k+1), per valid row i:
  - up = own previous output H[i-1][j], initialised to j*indel.
  - left = output of PE k-1 for this row. For PE0, left = i*indel.
  - diag = previous left value. For PE0, diag = (i-1)*indel.
  - H = max(diag + (c==q[k] ? match : mismatch), up + indel, left + indel).
  - The PE registers H, the character, the row valid bit and i toward PE k+1.
- PEs with k ≥ `q_len` do not affect `score`. `score` is taken from PE `q_len`-1.
- Arithmetic is signed two's complement in `SWIDTH`, wrapping with no saturation. Boundary products (i*indel) are accumulated by repeated addition, not multiplication.
- `start`, `q_load` and `q_clear` outside IDLE are ignored. `s_valid` in IDLE or DRAIN is ignored.
- Reset values: `s_ready`=0, `busy`=0, `score`=0, `score_valid`=0, `q_len`=0, `q_full`=0, state IDLE, all PE registers 0.
- Reset mid-run aborts the run with no `score_valid`, and the query is lost.

## Timing
- `start` is accepted at edge T0. `s_ready`=1 from the cycle after T0.
- Row i accepted at edge Ti is computed by PE k at edge Ti+k+1.
- `score` and `score_valid` assert in the cycle following edge Tlast + `q_len`. Latency is `q_len` cycles after the `s_last` handshake, independent of bubbles earlier in the stream.
- `busy` rises the cycle after T0 and falls in the same cycle `score_valid` is high.
- A new `start` is accepted in the cycle `score_valid` is high.
- `q_load` and `start` in the same IDLE cycle: the load happens first, and the run uses the new length.
- Throughput: one subject character per cycle.

## Test plan
- Weights 1/-1/-1, query ACGT (0,1,2,3), subject ACGT streamed back-to-back -> `score`=4, `score_valid` exactly 4 cycles after the `s_last` edge.
- Same weights, query ACGT, subject AGT -> `score`=2. Query A, subject C -> `score`=-1.
- Weights 2/-3/-2, query AC, subject AG -> `score`=-1. Rerun with the same query and weights 1/-1/-1 without reloading -> `score`=0.
- Query ACGT, subject ACGT with `s_valid` toggled every other cycle -> `score`=4, latency still 4 cycles after the `s_last` edge.
- Load 17 characters with `PE_COUNT`=16 -> `q_len`=16, `q_full`=1. `start` with `q_len`=0 -> `busy` stays 0.
- Assert `reset`=0 for one cycle mid-RUN -> next cycle: `busy`=0, `s_ready`=0, `q_len`=0, `score`=0, and no `score_valid` follows.
